// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS-lite control FSM with DM ready handshake, timeout and retire counter
module mc_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       fc,
    input  logic             br_e,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemWr,
    output logic             MemRd,
    output logic             ALUSrc2,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ExtOp,
    output logic [1:0]       nPC_sel,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [2:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
    } instr_t;

    state_t     cur, nxt;
    instr_t     instr;
    logic [7:0] wait_cnt;
    logic       timeout;
    logic       pc_wr, ir_wr, reg_wr, mem_wr, mem_rd;

    always_comb begin
        instr = I_NOP;
        if (op == 6'h00) begin
            case (fc)
                6'h21:   instr = I_ADDU;
                6'h23:   instr = I_SUBU;
                6'h08:   instr = I_JR;
                default: instr = I_NOP;
            endcase
        end else begin
            case (op)
                6'h0d:   instr = I_ORI;
                6'h23:   instr = I_LW;
                6'h2b:   instr = I_SW;
                6'h04:   instr = I_BEQ;
                6'h0f:   instr = I_LUI;
                6'h02:   instr = I_J;
                6'h03:   instr = I_JAL;
                default: instr = I_NOP;
            endcase
        end
    end

    // ready wins over timeout when both land in the same cycle
    assign timeout = (cur == S_MEM) && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt      = S_FETCH;
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        ALUSrc2  = 1'b0;
        ALUOp    = 2'b00;
        ExtOp    = 2'b00;
        nPC_sel  = 2'b00;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        case (cur)
            S_FETCH: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
                nxt   = S_DECODE;
            end
            S_DECODE: begin
                case (instr)
                    I_J: begin
                        pc_wr   = 1'b1;
                        nPC_sel = 2'b10;
                    end
                    I_JAL: begin
                        reg_wr   = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                        pc_wr    = 1'b1;
                        nPC_sel  = 2'b10;
                    end
                    I_JR: begin
                        pc_wr   = 1'b1;
                        nPC_sel = 2'b11;
                    end
                    I_NOP:   nxt = S_FETCH;
                    default: nxt = S_EXEC;
                endcase
            end
            S_EXEC, S_MEM: begin
                // MEM keeps the address computation stable while the access is pending
                case (instr)
                    I_ADDU: ALUOp = 2'b00;
                    I_SUBU: ALUOp = 2'b01;
                    I_ORI: begin
                        ALUOp   = 2'b10;
                        ALUSrc2 = 1'b1;
                    end
                    I_LUI: begin
                        ALUOp   = 2'b11;
                        ALUSrc2 = 1'b1;
                        ExtOp   = 2'b10;
                    end
                    I_LW, I_SW: begin
                        ALUSrc2 = 1'b1;
                        ExtOp   = 2'b01;
                    end
                    I_BEQ: begin
                        ALUOp = 2'b01;
                        ExtOp = 2'b01;
                    end
                    default: ;
                endcase
                if (cur == S_EXEC) begin
                    case (instr)
                        I_LW, I_SW:                    nxt = S_MEM;
                        I_ADDU, I_SUBU, I_ORI, I_LUI:  nxt = S_WB;
                        I_BEQ: begin
                            nxt = S_FETCH;
                            if (br_e) begin
                                pc_wr   = 1'b1;
                                nPC_sel = 2'b01;
                            end
                        end
                        default:                       nxt = S_FETCH;
                    endcase
                end else begin
                    mem_rd = (instr == I_LW);
                    mem_wr = (instr == I_SW);
                    if (mem_ready) begin
                        if (instr == I_LW) nxt = S_WB;
                        else               nxt = S_FETCH;
                    end else if (timeout) begin
                        nxt = S_FETCH;
                    end else begin
                        nxt = S_MEM;
                    end
                end
            end
            S_WB: begin
                reg_wr = 1'b1;
                case (instr)
                    I_ADDU, I_SUBU: RegDst   = 2'b01;
                    I_LW:           MemtoReg = 2'b01;
                    default: ;
                endcase
                nxt = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // enables are gated so no write can escape while reset is held
    assign PCWr  = pc_wr  & reset;
    assign IRWr  = ir_wr  & reset;
    assign RegWr = reg_wr & reset;
    assign MemWr = mem_wr & reset;
    assign MemRd = mem_rd & reset;
    assign state = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur      <= S_FETCH;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
            retired  <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_MEM && nxt == S_MEM) wait_cnt <= wait_cnt + 8'd1;
            else                              wait_cnt <= 8'd0;
            if (timeout) mem_err <= 1'b1;
            if (cur != S_FETCH && nxt == S_FETCH)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed bench comparing mc_controller with a per-instruction phase-list model
module tb_mc_controller;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, fc;
    logic        br_e, mem_ready;
    logic        PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc2;
    logic [1:0]  ALUOp, ExtOp, nPC_sel, RegDst, MemtoReg;
    logic [2:0]  state;
    logic        mem_err;
    logic [31:0] retired;

    always #5 clk = ~clk;

    mc_controller #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .fc(fc), .br_e(br_e), .mem_ready(mem_ready),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .MemRd(MemRd),
        .ALUSrc2(ALUSrc2), .ALUOp(ALUOp), .ExtOp(ExtOp), .nPC_sel(nPC_sel),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .state(state), .mem_err(mem_err),
        .retired(retired)
    );

    typedef enum int {C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL} cls_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        pcwr, irwr, regwr, memwr, memrd, alusrc2;
        logic [1:0]  aluop, extop, npc, regdst, memtoreg;
        logic        err;
        logic [31:0] ret;
    } obs_t;

    obs_t  obs, exp_o;
    bit    exp_valid = 1'b0;
    int    vectors = 0;
    int    fails = 0;
    string tag = "reset";
    int    m_ret = 0;
    bit    m_err = 1'b0;

    assign obs = {state, PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc2, ALUOp, ExtOp,
                  nPC_sel, RegDst, MemtoReg, mem_err, retired};

    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f == 6'h21) return C_ADDU;
            if (f == 6'h23) return C_SUBU;
            if (f == 6'h08) return C_JR;
            return C_NOP;
        end
        case (o)
            6'h0d:   return C_ORI;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h0f:   return C_LUI;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_NOP;
        endcase
    endfunction

    // {ALUSrc2, ALUOp, ExtOp} per instruction class
    function automatic logic [4:0] alu_ctl(input cls_t c);
        case (c)
            C_ADDU:     return 5'b0_00_00;
            C_SUBU:     return 5'b0_01_00;
            C_ORI:      return 5'b1_10_00;
            C_LUI:      return 5'b1_11_10;
            C_LW, C_SW: return 5'b1_00_01;
            C_BEQ:      return 5'b0_01_01;
            default:    return 5'b0_00_00;
        endcase
    endfunction

    function automatic obs_t model(input int ph, input cls_t c, input logic be,
                                   input logic err, input int ret);
        obs_t m = '0;
        m.st  = 3'(ph);
        m.err = err;
        m.ret = 32'(ret);
        case (ph)
            0: begin
                m.irwr = 1'b1;
                m.pcwr = 1'b1;
            end
            1: begin
                if (c == C_J || c == C_JAL) begin
                    m.pcwr = 1'b1;
                    m.npc  = 2'b10;
                end
                if (c == C_JAL) begin
                    m.regwr    = 1'b1;
                    m.regdst   = 2'b10;
                    m.memtoreg = 2'b10;
                end
                if (c == C_JR) begin
                    m.pcwr = 1'b1;
                    m.npc  = 2'b11;
                end
            end
            2, 3: begin
                {m.alusrc2, m.aluop, m.extop} = alu_ctl(c);
                if (ph == 2 && c == C_BEQ && be) begin
                    m.pcwr = 1'b1;
                    m.npc  = 2'b01;
                end
                if (ph == 3) begin
                    m.memrd = (c == C_LW);
                    m.memwr = (c == C_SW);
                end
            end
            4: begin
                m.regwr    = 1'b1;
                m.regdst   = (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
                m.memtoreg = (c == C_LW) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
        return m;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            vectors++;
            if (obs !== exp_o) begin
                fails++;
                $display("FAIL %s state%0d: got %h want %h", tag, exp_o.st, obs, exp_o);
            end
        end
    end

    task automatic check_lit(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // w = not-ready MEM cycles before ready; to = ready never comes; stop_after>0 cuts the run short
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic be, input int w, input bit to, input int stop_after,
                             output int cpi);
        cls_t c;
        int   seq[$];
        int   memk;
        c    = classify(o, f);
        memk = 0;
        seq  = {0, 1};
        if (c inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ}) begin
            seq.push_back(2);
            if (c == C_LW || c == C_SW) repeat (to ? TO : w + 1) seq.push_back(3);
            if ((c inside {C_ADDU, C_SUBU, C_ORI, C_LUI}) || (c == C_LW && !to)) seq.push_back(4);
        end
        tag  = name;
        op   = o;
        fc   = f;
        br_e = be;
        cpi  = 1;
        foreach (seq[i]) begin
            if (stop_after > 0 && i >= stop_after) break;
            mem_ready = (seq[i] == 3) && !to && (memk == w);
            if (seq[i] == 3) memk++;
            exp_o     = model(seq[i], c, be, m_err, m_ret);
            exp_valid = 1'b1;
            @(negedge clk);
            if (state != 3'd0) cpi++;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        if (stop_after == 0) begin
            m_ret++;
            if (to) m_err = 1'b1;
        end
    endtask

    initial begin
        int cpi;
        reset = 1'b0; op = 6'h00; fc = 6'h21; br_e = 1'b0; mem_ready = 1'b0;
        exp_o = '0; exp_valid = 1'b1; tag = "reset";
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        run_instr("addu", 6'h00, 6'h21, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("addu_cpi", cpi, 4);
        check_lit("addu_retired", retired, 1);
        run_instr("subu", 6'h00, 6'h23, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("subu_cpi", cpi, 4);
        run_instr("ori", 6'h0d, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        run_instr("lui", 6'h0f, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 1'b0, 0, cpi);
        check_lit("beq_taken_cpi", cpi, 3);
        run_instr("beq_not", 6'h04, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("beq_not_cpi", cpi, 3);
        run_instr("lw_w2", 6'h23, 6'h00, 1'b0, 2, 1'b0, 0, cpi);
        check_lit("lw_w2_cpi", cpi, 7);
        run_instr("sw_w0", 6'h2b, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("sw_w0_cpi", cpi, 4);
        check_lit("mem_err_clear", mem_err, 0);
        run_instr("sw_timeout", 6'h2b, 6'h00, 1'b0, 0, 1'b1, 0, cpi);
        check_lit("sw_timeout_cpi", cpi, 3 + TO);
        check_lit("mem_err_set", mem_err, 1);
        check_lit("retired_9", retired, 9);
        run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("jal_cpi", cpi, 2);
        run_instr("op3f", 6'h3f, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("op3f_cpi", cpi, 2);
        check_lit("retired_11", retired, 11);
        run_instr("j", 6'h02, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("jr_cpi", cpi, 2);
        run_instr("nop", 6'h00, 6'h00, 1'b0, 0, 1'b0, 0, cpi);
        run_instr("r_unknown", 6'h00, 6'h20, 1'b0, 0, 1'b0, 0, cpi);
        run_instr("lw_timeout", 6'h23, 6'h00, 1'b0, 0, 1'b1, 0, cpi);
        check_lit("lw_timeout_cpi", cpi, 3 + TO);
        run_instr("lw_after_err", 6'h23, 6'h00, 1'b0, 1, 1'b0, 0, cpi);
        check_lit("lw_w1_cpi", cpi, 6);
        check_lit("retired_17", retired, 17);
        check_lit("mem_err_sticky", mem_err, 1);

        run_instr("lw_cut", 6'h23, 6'h00, 1'b0, 100, 1'b0, 5, cpi);
        reset = 1'b0;
        exp_o = '0;
        tag   = "mid_reset";
        m_ret = 0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_instr("addu_post", 6'h00, 6'h21, 1'b0, 0, 1'b0, 0, cpi);
        check_lit("post_reset_retired", retired, 1);
        check_lit("post_reset_err", mem_err, 0);

        exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the MIPS-lite datapath. It sequences the shared ALU, register file, instruction register and data memory across FETCH/DECODE/EXEC/MEM/WB cycles.
- It replaces the single-cycle combinational controller.
- It decodes the latched IR fields op/fc and adds a data-memory ready handshake with timeout, plus a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ready before abort (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op  input  6  IR[31:26], stable from DECODE onward.
- fc  input  6  IR[5:0].
- br_e  input  1  ALU equality flag (A==B), valid in EXEC.
- mem_ready  input  1  DM completion strobe for the current access.
- PCWr  output  1  PC register write enable.
- IRWr  output  1  IR write enable.
- RegWr  output  1  GRF write enable.
- MemWr  output  1  DM write request.
- MemRd  output  1  DM read request.
- ALUSrc2  output  1  ALU B operand select: 0 = RegB, 1 = ExtOut.
- ALUOp  output  2  ALU operation: 00 add, 01 sub, 10 or, 11 lui.
- ExtOp  output  2  immediate extension: 00 zero, 01 sign, 10 upper.
- nPC_sel  output  2  next-PC select: 00 PC+4, 01 branch, 10 imm26 jump, 11 jr (RegA).
- RegDst  output  2  write-register select: 00 rt, 01 rd, 10 $31.
- MemtoReg  output  2  write-data select: 00 ALUOut, 01 DM data, 10 PC.
- state  output  3  current state, for debug.
- mem_err  output  1  sticky timeout flag.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Encodings 5–7 are illegal and go to FETCH.
- Reset (reset = 0, asynchronous):
  - state = FETCH; wait counter = 0; mem_err = 0; retired = 0.
  - All enables (PCWr, IRWr, RegWr, MemWr, MemRd) are forced to 0 while reset is low.
  - The first FETCH occurs on the first rising edge after reset deasserts.
- Supported instructions:
  - R-type (op = 0): addu (fc = 0x21), subu (fc = 0x23), jr (fc = 0x08); fc = 0x00 is nop.
  - I/J-type: ori (0x0d), lw (0x23), sw (0x2b), beq (0x04), lui (0x0f), j (0x02), jal (0x03).
  - Anything else is treated as nop.
- Output timing: outputs are combinational from state, op, fc and br_e. Every enable is a single-cycle pulse and is 0 unless stated below.
- FETCH: IRWr = 1, PCWr = 1, nPC_sel = 00; next state DECODE.
- DECODE:
  - j: PCWr = 1, nPC_sel = 10; next FETCH.
  - jal: RegWr = 1, RegDst = 10, MemtoReg = 10 (PC already holds PC+4), PCWr = 1, nPC_sel = 10; next FETCH.
  - jr: PCWr = 1, nPC_sel = 11; next FETCH.
  - nop/unknown: next FETCH.
  - All other instructions: next EXEC.
- EXEC:
  - addu: ALUOp = 00, ALUSrc2 = 0.
  - subu: ALUOp = 01, ALUSrc2 = 0.
  - ori: ALUOp = 10, ALUSrc2 = 1, ExtOp = 00.
  - lui: ALUOp = 11, ALUSrc2 = 1, ExtOp = 10.
  - lw/sw: ALUOp = 00, ALUSrc2 = 1, ExtOp = 01.
  - beq: ALUOp = 01, ExtOp = 01. If br_e = 1, PCWr = 1 and nPC_sel = 01 (target = PC+4+sext(imm)<<2).
  - Next state: arith → WB; lw/sw → MEM; beq → FETCH.
- MEM:
  - Outputs: MemRd = 1 (lw) or MemWr = 1 (sw); ALUOp/ALUSrc2/ExtOp are held from EXEC. These stay asserted every cycle until exit. DM commits a store only on the edge where mem_ready = 1.
  - On mem_ready = 1: sw → FETCH; lw → WB.
  - Wait counter increments each MEM cycle with mem_ready = 0. If it reaches MEM_TIMEOUT: mem_err = 1 (sticky until reset), no register write occurs, next FETCH.
  - The abort counts as retired.
  - Wait counter clears on MEM exit.
- WB: RegWr = 1.
  - addu/subu: RegDst = 01, MemtoReg = 00.
  - ori/lui: RegDst = 00, MemtoReg = 00.
  - lw: RegDst = 00, MemtoReg = 01.
  - Next state: FETCH.
- retired: increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^CNT_W.
- CPI: j/jal/jr/nop = 2; beq = 3; arith = 4; sw = 4+w; lw = 5+w, where w = cycles with mem_ready = 0.
- Reset mid-instruction: the FSM aborts immediately; no partial write is permitted after reset falls.

Test Plan:
- Reset low for 3 cycles, then high → state 0→1 sequence begins; IRWr = PCWr = 1 on the first cycle; retired = 0; all enables 0 during reset.
- addu (op = 0, fc = 0x21) → states 0,1,2,4,0; RegWr = 1 only in WB with RegDst = 01; retired = 1.
- beq with br_e = 1 then br_e = 0 → PCWr = 1, nPC_sel = 01 in EXEC only for the first; both return to FETCH after 3 cycles.
- lw with mem_ready low 2 cycles then high → MemRd high 3 cycles, then WB with MemtoReg = 01, RegDst = 00; total 7 cycles.
- sw with mem_ready held 0 and MEM_TIMEOUT = 15 → after 15 MEM cycles mem_err = 1, next state FETCH, no RegWr.
- jal → DECODE asserts RegWr, RegDst = 10, MemtoReg = 10, PCWr, nPC_sel = 10; 2-cycle instruction. Then op = 0x3f → treated as nop, 2 cycles, retired += 1.
